pkt_egress_reader: RTL and testbench
====================================

// Module: pkt_egress_reader
// PURPOSE
//  Read-side packet engine for the packet-processor internal buffer. Drains whole packets word by word
//  via rd_en/rd_data, frames them with sop/eop and presents them on a valid/ready egress stream.
//  Never reads an empty buffer (no underflow). Absorbs the buffer's 1-cycle read latency and downstream
//  back-pressure in a small skid FIFO.
// PARAMETERS
//  DATA_WIDTH     32    buffer / egress word width
//  PCK_LEN        12    width of header length field and remaining-word counter
//  MAX_PKT_WORDS  2048  largest legal packet length in words, header included
//  SKID_DEPTH     4     output FIFO entries, power of 2, >=2
// PORTS
//  clk           in   1           clock
//  hw_rst        in   1           reset, synchronous, active-high
//  buffer_empty  in   1           buffer has no readable word
//  rd_en         out  1           read strobe to buffer; data valid on rd_data next cycle
//  rd_data       in   DATA_WIDTH  buffer read data, registered in buffer
//  out_data      out  DATA_WIDTH  egress word
//  out_valid     out  1           egress word valid
//  out_ready     in   1           downstream accepts when out_valid & out_ready
//  out_sop       out  1           first word of packet (header)
//  out_eop       out  1           last word of packet
//  out_err       out  1           word belongs to a bad-length packet
//  len_err       out  1           1-cycle pulse, bad header length detected
//  pkt_count     out  32          packets whose eop was accepted downstream, wraps
//  busy          out  1           state != IDLE or FIFO non-empty
// BEHAVIOUR
//  Reset (hw_rst=1 at clk edge): state IDLE, FIFO and in-flight tag cleared. All outputs 0 in the next
//   cycle. rd_en is combinationally 0 while hw_rst=1. A reset mid-packet discards the partial packet.
//  Header word: bits [PCK_LEN-1:0] = LEN, total words incl. header. Legal range 2..MAX_PKT_WORDS.
//  Credit rule: rd_en may assert only if buffer_empty=0, hw_rst=0 and
//   fifo_cnt + inflight - pop < SKID_DEPTH, where pop = out_valid & out_ready and inflight = rd_en one
//   cycle earlier. A FIFO push is therefore never refused.
//  FSM:
//   IDLE: if credit ok, rd_en=1 tagged sop, go to HDR_WAIT.
//   HDR_WAIT: header on rd_data. Push {sop=1, data}.
//    LEN illegal: push with eop=1, err=1, pulse len_err, go to IDLE.
//    LEN legal: rem <= LEN-1, go to BODY.
//   BODY: while rem != 0 and credit ok, rd_en=1 and rem decrements. Read with rem==1 is tagged eop.
//    After the eop read is issued, go to IDLE. Data is pushed one cycle after each rd_en.
//   buffer_empty=1 in BODY stalls reads; state and rem are held; no timeout.
//  One bubble cycle per packet (HDR_WAIT). Sustained rate is 1 word/clk in BODY with out_ready=1.
//  Latency: rd_en to out_valid is 2 cycles when the FIFO is empty (buffer register, FIFO push).
//  Egress: out_* held stable while out_valid=1 and out_ready=0. FIFO is first-word-fall-through and
//   supports push and pop in the same cycle.
//  Simultaneous push on a full FIFO with pop is legal. Push on a full FIFO without pop cannot occur.
//   The bench asserts this never happens.
//  pkt_count increments on out_valid & out_ready & out_eop; 32-bit modular wrap.
//  Widths: rem is PCK_LEN bits. The LEN comparison is unsigned. LEN=0 and LEN=1 are illegal.
// STRUCTURE
//  pkt_proc_pkg: egress_state_t enum {IDLE, HDR_WAIT, BODY}; localparams HDR_LEN_LSB=0, MIN_PKT_WORDS=2;
//   struct egress_word_t {sop, eop, err, data}.
//  Sub-module egress_skid_fifo (#WIDTH, #DEPTH): sync FIFO with push, pop, count, full, empty and
//   synchronous active-high reset. Holds egress_word_t.
//  Top level: FSM, rem counter, in-flight tag register, credit logic, pkt_count.
// TESTING
//  1 Buffer holds one packet, LEN=4, out_ready=1. rd_en high for 1 cycle, gap, then 3 cycles. Egress
//    gives 4 words, sop on word0, eop on word3. pkt_count=1.
//  2 Same packet, out_ready=0 for 10 cycles. Reads stop at SKID_DEPTH=4 outstanding. out_data stable.
//    Release gives in-order delivery with no drop or duplicate.
//  3 LEN=6 packet with buffer_empty=1 for 5 cycles after 3 words. rd_en=0 while empty. Resumes and
//    ends with eop on word 6. No underflow read.
//  4 Header LEN=1, then header LEN=3000 (>2048). Each gives a 1-word packet with sop=eop=err=1 and a
//    len_err pulse. pkt_count increments by 2.
//  5 hw_rst=1 for 1 cycle mid-BODY of a LEN=8 packet. Next cycle out_valid=0, busy=0, pkt_count=0.
//    A new LEN=2 packet is then read cleanly.
//  6 Back-to-back LEN=2 packets x100 with random out_ready. 200 words in order, pkt_count=100, no
//    FIFO overflow assertion.

Source files
------------

// File: rtl/pkt_proc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pkt_proc_pkg
// Description : Shared types and constants for the packet-processor egress path.
// Revision    : 1.0 - initial release
// ============================================================================
package pkt_proc_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HDR_WAIT = 2'd1,
        BODY     = 2'd2
    } egress_state_t;

    localparam int HDR_LEN_LSB    = 0;
    localparam int MIN_PKT_WORDS  = 2;
    localparam int PKT_DATA_WIDTH = 32;

    typedef struct packed {
        logic                      sop;
        logic                      eop;
        logic                      err;
        logic [PKT_DATA_WIDTH-1:0] data;
    } egress_word_t;

endpackage : pkt_proc_pkg
`default_nettype wire

// File: rtl/egress_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module      : egress_skid_fifo
// Description : First-word-fall-through sync FIFO; push and pop may share a cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module egress_skid_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    // A full FIFO still accepts a push when the same cycle frees a slot.
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

endmodule : egress_skid_fifo
`default_nettype wire

// File: rtl/pkt_egress_reader.sv
`default_nettype none
// ============================================================================
// Module      : pkt_egress_reader
// Description : Drains whole packets from the internal buffer onto a framed valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_egress_reader
    import pkt_proc_pkg::*;
#(
    parameter int DATA_WIDTH    = PKT_DATA_WIDTH,
    parameter int PCK_LEN       = 12,
    parameter int MAX_PKT_WORDS = 2048,
    parameter int SKID_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  hw_rst,
    input  logic                  buffer_empty,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic                  out_err,
    output logic                  len_err,
    output logic [31:0]           pkt_count,
    output logic                  busy
);

    localparam int CW = $clog2(SKID_DEPTH) + 1;

    egress_state_t      r_state;
    egress_state_t      w_state_nxt;
    logic [PCK_LEN-1:0] r_rem;
    logic [PCK_LEN-1:0] w_rem_nxt;
    logic               r_inflight;
    logic               r_tag_sop;
    logic               r_tag_eop;
    logic               r_len_err;
    logic [31:0]        r_pkt_count;

    logic               w_rd_tag_sop;
    logic               w_rd_tag_eop;
    logic               w_rd_ok;
    logic               w_credit;
    logic               w_pop;
    logic [PCK_LEN-1:0] w_len;
    logic               w_len_ok;
    logic               w_fifo_push;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [CW-1:0]      w_fifo_cnt;
    logic [CW:0]        w_occ;
    logic [CW:0]        w_lim;
    egress_word_t       w_push_word;
    egress_word_t       w_head_raw;
    egress_word_t       w_head;

    assign w_len    = rd_data[HDR_LEN_LSB +: PCK_LEN];
    assign w_len_ok = (32'(w_len) >= 32'(MIN_PKT_WORDS)) && (32'(w_len) <= 32'(MAX_PKT_WORDS));

    // Occupancy counts the word still inside the buffer register so a push is never refused.
    assign w_pop    = out_valid & out_ready;
    assign w_occ    = {1'b0, w_fifo_cnt} + (CW+1)'(r_inflight);
    assign w_lim    = (CW+1)'(SKID_DEPTH) + (CW+1)'(w_pop);
    assign w_credit = (w_occ < w_lim);
    assign w_rd_ok  = w_credit & ~buffer_empty & ~hw_rst;

    always_comb begin
        w_state_nxt  = r_state;
        w_rem_nxt    = r_rem;
        rd_en        = 1'b0;
        w_rd_tag_sop = 1'b0;
        w_rd_tag_eop = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rd_ok) begin
                    rd_en        = 1'b1;
                    w_rd_tag_sop = 1'b1;
                    w_state_nxt  = HDR_WAIT;
                end
            end
            HDR_WAIT: begin
                if (w_len_ok) begin
                    w_rem_nxt   = w_len - PCK_LEN'(1);
                    w_state_nxt = BODY;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            BODY: begin
                if (w_rd_ok && (r_rem != '0)) begin
                    rd_en     = 1'b1;
                    w_rem_nxt = r_rem - PCK_LEN'(1);
                    if (r_rem == PCK_LEN'(1)) begin
                        w_rd_tag_eop = 1'b1;
                        w_state_nxt  = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The header word frames itself: a bad length turns it into a one-word error packet.
    always_comb begin
        w_fifo_push      = r_inflight;
        w_push_word      = '0;
        w_push_word.sop  = r_tag_sop;
        w_push_word.eop  = r_tag_sop ? ~w_len_ok : r_tag_eop;
        w_push_word.err  = r_tag_sop & ~w_len_ok;
        w_push_word.data = rd_data;
    end

    always_ff @(posedge clk) begin
        if (hw_rst) begin
            r_state     <= IDLE;
            r_rem       <= '0;
            r_inflight  <= 1'b0;
            r_tag_sop   <= 1'b0;
            r_tag_eop   <= 1'b0;
            r_len_err   <= 1'b0;
            r_pkt_count <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rem      <= w_rem_nxt;
            r_inflight <= rd_en;
            r_tag_sop  <= w_rd_tag_sop;
            r_tag_eop  <= w_rd_tag_eop;
            r_len_err  <= (r_state == HDR_WAIT) & ~w_len_ok;
            if (w_pop && w_head.eop) begin
                r_pkt_count <= r_pkt_count + 32'd1;
            end
        end
    end

    egress_skid_fifo #(
        .WIDTH ($bits(egress_word_t)),
        .DEPTH (SKID_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (hw_rst),
        .i_push  (w_fifo_push),
        .i_wdata (w_push_word),
        .i_pop   (w_pop),
        .o_rdata (w_head_raw),
        .o_count (w_fifo_cnt),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_head    = w_fifo_empty ? '0 : w_head_raw;
    assign out_valid = ~w_fifo_empty;
    assign out_data  = w_head.data;
    assign out_sop   = w_head.sop;
    assign out_eop   = w_head.eop;
    assign out_err   = w_head.err;
    assign len_err   = r_len_err;
    assign pkt_count = r_pkt_count;
    assign busy      = (r_state != IDLE) | ~w_fifo_empty;

endmodule : pkt_egress_reader
`default_nettype wire

// File: tb/tb_pkt_egress_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_pkt_egress_reader
// Description : Scoreboard bench for pkt_egress_reader with a registered buffer model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pkt_egress_reader;

    localparam int DW        = 32;
    localparam int BUF_DEPTH = 4096;

    logic          clk = 1'b0;
    logic          hw_rst;
    logic          buffer_empty;
    logic          rd_en;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_sop;
    logic          out_eop;
    logic          out_err;
    logic          len_err;
    logic [31:0]   pkt_count;
    logic          busy;

    logic [DW-1:0] buf_mem [BUF_DEPTH];
    int            wr_idx = 0;
    int            rd_idx = 0;
    logic [34:0]   exp_q[$];
    logic [DW-1:0] stage_q[$];
    logic [34:0]   exp_word;

    int n_checks = 0;
    int n_errors = 0;
    int rd_cnt   = 0;
    int lerr_cnt = 0;
    int ovf_cnt  = 0;
    int udf_cnt  = 0;
    int exp_pkts = 0;
    bit   ready_rand  = 1'b0;
    logic ready_fixed = 1'b0;

    always #5 clk = ~clk;

    pkt_egress_reader dut (
        .clk          (clk),
        .hw_rst       (hw_rst),
        .buffer_empty (buffer_empty),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sop      (out_sop),
        .out_eop      (out_eop),
        .out_err      (out_err),
        .len_err      (len_err),
        .pkt_count    (pkt_count),
        .busy         (busy)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Buffer model: registered read port, flushed by reset.
    assign buffer_empty = (wr_idx == rd_idx);
    always @(posedge clk) begin
        if (hw_rst) begin
            rd_idx <= wr_idx;
        end else if (rd_en) begin
            if (wr_idx == rd_idx) begin
                udf_cnt <= udf_cnt + 1;
            end else begin
                rd_data <= buf_mem[rd_idx % BUF_DEPTH];
                rd_idx  <= rd_idx + 1;
            end
        end
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_fixed;
        end
    end

    always @(negedge clk) begin
        if (rd_en) rd_cnt++;
        if (len_err) lerr_cnt++;
        if (dut.w_fifo_push && dut.w_fifo_full && !dut.w_pop) ovf_cnt++;
        if (out_valid && out_ready && !hw_rst) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_word", 64'(out_data), 64'hDEAD_0000_0000);
            end else begin
                exp_word = exp_q.pop_front();
                check_val("egress_word", {out_sop, out_eop, out_err, out_data}, exp_word);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic gen_pkt(input int len);
        logic [DW-1:0] w;
        w       = $urandom();
        w[11:0] = 12'(len);
        stage_q.push_back(w);
        exp_q.push_back({1'b1, 1'b0, 1'b0, w});
        for (int i = 1; i < len; i++) begin
            w = $urandom();
            stage_q.push_back(w);
            exp_q.push_back({1'b0, (i == len - 1), 1'b0, w});
        end
        exp_pkts++;
    endtask

    task automatic gen_bad(input int len);
        logic [DW-1:0] w;
        w       = $urandom();
        w[11:0] = 12'(len);
        stage_q.push_back(w);
        exp_q.push_back({3'b111, w});
        exp_pkts++;
    endtask

    task automatic feed(input int n);
        repeat (n) begin
            buf_mem[wr_idx % BUF_DEPTH] = stage_q.pop_front();
            wr_idx++;
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy || !buffer_empty) && n < budget) begin
            step();
            n++;
        end
        check_val(tag, 64'(n >= budget), 64'd0);
    endtask

    initial begin
        logic [5:0]    rd_pat;
        logic [5:0]    v_pat;
        logic          busy1;
        logic [DW-1:0] d0;
        int            base;
        int            n;

        hw_rst = 1'b1;
        step(3);
        hw_rst = 1'b0;
        check_val("rst_flags", {out_valid, out_sop, out_eop, out_err, len_err, busy, rd_en}, 7'b0);
        check_val("rst_out_data", out_data, 0);
        check_val("rst_pkt_count", pkt_count, 0);

        // T1: single LEN=4 packet, free-flowing egress
        ready_fixed = 1'b1;
        step(2);
        base = rd_cnt;
        gen_pkt(4);
        feed(4);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rd_pat[5-i] = rd_en;
            v_pat[5-i]  = out_valid;
            if (i == 1) busy1 = busy;
        end
        check_val("t1_rd_pattern", rd_pat, 6'b101110);
        check_val("t1_valid_latency", v_pat, 6'b001011);
        check_val("t1_busy", busy1, 1'b1);
        step();
        drain("t1_drain_timeout", 100);
        check_val("t1_reads", rd_cnt - base, 4);
        check_val("t1_pkt_count", pkt_count, exp_pkts);

        // T2: back-pressure, reads stop at skid depth, head held stable
        ready_fixed = 1'b0;
        step(2);
        base = rd_cnt;
        gen_pkt(4);
        gen_pkt(4);
        feed(8);
        step(6);
        d0 = out_data;
        step(6);
        check_val("t2_reads_held", rd_cnt - base, 4);
        check_val("t2_data_stable", out_data, d0);
        check_val("t2_head_flags", {out_valid, out_sop, out_eop}, 3'b110);
        ready_fixed = 1'b1;
        drain("t2_drain_timeout", 100);
        check_val("t2_reads", rd_cnt - base, 8);
        check_val("t2_pkt_count", pkt_count, exp_pkts);

        // T3: buffer runs dry mid-body
        base = rd_cnt;
        gen_pkt(6);
        feed(3);
        step(8);
        check_val("t3_reads_stalled", rd_cnt - base, 3);
        check_val("t3_busy", busy, 1'b1);
        feed(3);
        drain("t3_drain_timeout", 100);
        check_val("t3_reads", rd_cnt - base, 6);
        check_val("t3_pkt_count", pkt_count, exp_pkts);

        // T4: illegal lengths and the largest legal packet
        base = lerr_cnt;
        gen_bad(1);
        gen_bad(3000);
        gen_bad(0);
        gen_bad(2049);
        gen_pkt(2048);
        n = stage_q.size();
        feed(n);
        drain("t4_drain_timeout", 5000);
        check_val("t4_len_err_pulses", lerr_cnt - base, 4);
        check_val("t4_pkt_count", pkt_count, exp_pkts);

        // T5: reset in the middle of a LEN=8 body
        base = rd_cnt;
        gen_pkt(8);
        feed(8);
        n = 0;
        while ((rd_cnt - base) < 4 && n < 50) begin
            step();
            n++;
        end
        check_val("t5_reads_started", 64'(n < 50), 64'd1);
        hw_rst = 1'b1;
        #1;
        check_val("t5_rd_en_in_reset", rd_en, 1'b0);
        step();
        hw_rst = 1'b0;
        exp_q.delete();
        stage_q.delete();
        exp_pkts = 0;
        check_val("t5_out_valid", out_valid, 1'b0);
        check_val("t5_busy", busy, 1'b0);
        check_val("t5_pkt_count", pkt_count, 0);
        gen_pkt(2);
        feed(2);
        drain("t5_drain_timeout", 100);
        check_val("t5_pkt_after", pkt_count, exp_pkts);

        // T6: 100 back-to-back LEN=2 packets with random back-pressure
        ready_rand = 1'b1;
        for (int i = 0; i < 100; i++) gen_pkt(2);
        feed(200);
        drain("t6_drain_timeout", 3000);
        ready_rand = 1'b0;
        check_val("t6_pkt_count", pkt_count, exp_pkts);

        check_val("fifo_overflow", ovf_cnt, 0);
        check_val("buffer_underflow", udf_cnt, 0);
        check_val("scoreboard_left", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pkt_egress_reader
`default_nettype wire
